// File: rtl/mem_burst_reader_pkg.sv
// Shared types and constants for the burst reader and its output FIFO.
package mem_burst_reader_pkg;

  // Burst controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Output buffer depth: two entries allow full throughput while absorbing
  // one cycle of downstream backpressure.
  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/mem_burst_fifo.sv
// Small synchronous FIFO holding {last, data} beats between memory and output.
// Push is honoured when not full, or when full and popped the same cycle.
// Entries reset to zero so the head reads 0 while empty after reset.
module mem_burst_fifo
  import mem_burst_reader_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_empty,
  output logic         o_full
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  logic [W-1:0]  r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_dout    = r_mem[r_rptr];

  // Storage, pointers and occupancy; a pointer wraps naturally at FIFO_DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_do_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + {{PW{1'b0}}, w_do_push} - {{PW{1'b0}}, w_do_pop};
    end
  end

endmodule

// File: rtl/mem_burst_reader.sv
// Burst memory reader: walks len words from base_addr (wrapping at DEPTH)
// through a combinational-read memory and streams them out as valid/ready beats.
// Handshake: a beat transfers on a rising edge where out_valid && out_ready;
// while out_valid=1 and out_ready=0, out_data/out_last hold and out_valid stays high.
module mem_burst_reader
  import mem_burst_reader_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW:0]      len,
  output logic [AW-1:0]    mem_addr,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output state_t           dbg_state
);

  state_t          r_state;
  state_t          w_next_state;
  logic [AW-1:0]   r_addr;
  logic [AW:0]     r_rem;
  logic            r_done;
  logic            w_done_next;
  logic            w_accept;
  logic            w_capture;
  logic            w_pop;
  logic            w_empty;
  logic            w_full;
  logic            w_rem_one;
  logic [WIDTH:0]  w_head;

  assign w_rem_one = (r_rem == (AW+1)'(1));
  assign w_accept  = (r_state == IDLE) && start && (len != '0);
  assign w_pop     = out_valid && out_ready;
  assign w_capture = (r_state == READ) && (!w_full || w_pop);

  // Next-state and completion-pulse decode.
  always_comb begin
    w_next_state = r_state;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && (len == '0)) w_done_next  = 1'b1;
        else if (w_accept)        w_next_state = READ;
      end
      READ: begin
        if (w_capture && w_rem_one) w_next_state = DRAIN;
      end
      DRAIN: begin
        if (w_pop && w_head[WIDTH]) begin
          w_next_state = IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State register and registered done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_done_next;
    end
  end

  // Read address: loaded on accept, advanced per capture, wraps DEPTH-1 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (w_accept) begin
      r_addr <= base_addr;
    end else if (w_capture) begin
      r_addr <= (r_addr == AW'(DEPTH - 1)) ? '0 : r_addr + 1'b1;
    end
  end

  // Remaining-word counter: loaded on accept, decremented per capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
    end else if (w_accept) begin
      r_rem <= len;
    end else if (w_capture) begin
      r_rem <= r_rem - 1'b1;
    end
  end

  mem_burst_fifo #(
    .W (WIDTH + 1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_capture),
    .i_din   ({w_rem_one, mem_rdata}),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign mem_addr  = r_addr;
  assign out_valid = !w_empty;
  assign out_data  = w_head[WIDTH-1:0];
  assign out_last  = w_head[WIDTH] && !w_empty;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_burst_reader.sv
// Testbench for mem_burst_reader: memory model, scoreboard of expected beats,
// and one task per scenario.
module tb_mem_burst_reader;
  import mem_burst_reader_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [AW-1:0]    base_addr = '0;
  logic [AW:0]      len = '0;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_rdata;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             busy;
  logic             done;
  state_t           dbg_state;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH:0]   exp_q [$];

  int n_checks = 0;
  int n_errors = 0;
  int beats_seen = 0;
  int done_cnt = 0;
  logic           stall_prev = 1'b0;
  logic [WIDTH:0] held = '0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion within 500000 time units");
    $fatal(1);
  end

  mem_burst_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  assign mem_rdata = mem[mem_addr];

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [WIDTH:0] e;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        n_checks++;
        if (out_valid !== 1'b1 || {out_last, out_data} !== held) begin
          n_errors++;
          $display("FAIL stall_hold: got valid=%0b last_data=%h, expected valid=1 last_data=%h",
                   out_valid, {out_last, out_data}, held);
        end
      end
      if (done === 1'b1) done_cnt++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL beat_unexpected: got last_data=%h, expected no beat", {out_last, out_data});
        end else begin
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e) begin
            n_errors++;
            $display("FAIL beat_data: got last_data=%h, expected %h", {out_last, out_data}, e);
          end
        end
        beats_seen++;
      end
      stall_prev = out_valid && !out_ready;
      held       = {out_last, out_data};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic void push_exp(input logic [AW-1:0] b, input int l);
    for (int i = 0; i < l; i++) begin
      logic [AW-1:0] a;
      a = b + AW'(i);
      exp_q.push_back({(i == l - 1), mem[a]});
    end
  endfunction

  task automatic issue_now(input logic [AW-1:0] b, input int l);
    start = 1'b1;
    base_addr = b;
    len = (AW+1)'(l);
    push_exp(b, l);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic issue(input logic [AW-1:0] b, input int l);
    @(posedge clk);
    #1;
    issue_now(b, l);
  endtask

  task automatic wait_done(input int max_cyc, output int cyc);
    cyc = -1;
    for (int k = 1; k <= max_cyc; k++) begin
      tick();
      if (done === 1'b1) begin
        cyc = k;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %0b, expected 0", out_valid); end
    n_checks++; if (out_last !== 1'b0) begin n_errors++; $display("FAIL rst_last: got %0b, expected 0", out_last); end
    n_checks++; if (out_data !== 8'h00) begin n_errors++; $display("FAIL rst_data: got %h, expected 00", out_data); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_errors++; $display("FAIL rst_busy_done: got %0b%0b, expected 00", busy, done); end
    n_checks++; if (mem_addr !== 8'h00) begin n_errors++; $display("FAIL rst_addr: got %h, expected 00", mem_addr); end
    n_checks++; if (dbg_state !== IDLE) begin n_errors++; $display("FAIL rst_state: got %0d, expected %0d", dbg_state, IDLE); end
    repeat (2) @(posedge clk);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_burst();
    int d0;
    d0 = done_cnt;
    out_ready = 1'b1;
    issue(8'h10, 4);
    tick();
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin n_errors++; $display("FAIL burst_accept: got valid=%0b busy=%0b, expected valid=0 busy=1", out_valid, busy); end
    n_checks++; if (dbg_state !== READ) begin n_errors++; $display("FAIL burst_state: got %0d, expected %0d", dbg_state, READ); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL burst_latency: got valid=%0b, expected 1", out_valid); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++; if (out_valid !== 1'b1 || done !== 1'b0) begin n_errors++; $display("FAIL burst_stream: cycle %0d got valid=%0b done=%0b, expected valid=1 done=0", k, out_valid, done); end
    end
    tick();
    n_checks++; if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin n_errors++; $display("FAIL burst_done: got done=%0b busy=%0b valid=%0b, expected 1 0 0", done, busy, out_valid); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL burst_done_width: got %0b, expected 0", done); end
    n_checks++; if (exp_q.size() != 0 || done_cnt - d0 != 1) begin n_errors++; $display("FAIL burst_complete: got left=%0d dones=%0d, expected 0 and 1", exp_q.size(), done_cnt - d0); end
  endtask

  task automatic test_wrap();
    int cyc;
    out_ready = 1'b1;
    issue(8'hFE, 4);
    wait_done(30, cyc);
    n_checks++; if (cyc < 0) begin n_errors++; $display("FAIL wrap_timeout: got no done, expected done"); end
    n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL wrap_left: got %0d, expected 0", exp_q.size()); end
    n_checks++; if (mem_addr !== 8'h02) begin n_errors++; $display("FAIL wrap_addr: got %h, expected 02", mem_addr); end
  endtask

  task automatic test_backpressure();
    int b0, d0, i;
    logic seen;
    b0 = beats_seen;
    d0 = done_cnt;
    seen = 1'b0;
    out_ready = 1'b0;
    issue(8'h30, 8);
    for (i = 0; i < 100; i++) begin
      @(posedge clk);
      #1 out_ready = (i % 3 == 0);
      tick();
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    out_ready = 1'b1;
    n_checks++; if (!seen) begin n_errors++; $display("FAIL bp_timeout: got no done, expected done"); end
    n_checks++; if (beats_seen - b0 != 8) begin n_errors++; $display("FAIL bp_count: got %0d beats, expected 8", beats_seen - b0); end
    n_checks++; if (exp_q.size() != 0 || done_cnt - d0 != 1) begin n_errors++; $display("FAIL bp_complete: got left=%0d dones=%0d, expected 0 and 1", exp_q.size(), done_cnt - d0); end
  endtask

  task automatic test_len0();
    int d0, b0;
    d0 = done_cnt;
    b0 = beats_seen;
    issue(8'h55, 0);
    tick();
    n_checks++; if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin n_errors++; $display("FAIL len0_done: got done=%0b busy=%0b valid=%0b, expected 1 0 0", done, busy, out_valid); end
    tick();
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL len0_after: got done=%0b busy=%0b, expected 0 0", done, busy); end
    n_checks++; if (mem_addr !== 8'h38) begin n_errors++; $display("FAIL len0_addr: got %h, expected 38", mem_addr); end
    n_checks++; if (done_cnt - d0 != 1 || beats_seen != b0) begin n_errors++; $display("FAIL len0_count: got dones=%0d beats=%0d, expected 1 0", done_cnt - d0, beats_seen - b0); end
  endtask

  task automatic test_overlap();
    int cyc, b0, d0;
    logic stray;
    b0 = beats_seen;
    d0 = done_cnt;
    stray = 1'b0;
    out_ready = 1'b1;
    issue(8'h20, 6);
    tick();
    tick();
    issue(8'h80, 0);
    start = 1'b1; base_addr = 8'h80; len = 9'd3;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(30, cyc);
    n_checks++; if (cyc < 0) begin n_errors++; $display("FAIL ovl_timeout: got no done, expected done"); end
    n_checks++; if (mem_addr !== 8'h26) begin n_errors++; $display("FAIL ovl_addr: got %h, expected 26", mem_addr); end
    for (int k = 0; k < 4; k++) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) stray = 1'b1;
    end
    n_checks++; if (stray) begin n_errors++; $display("FAIL ovl_stray: got activity after done, expected idle"); end
    n_checks++; if (beats_seen - b0 != 6 || exp_q.size() != 0 || done_cnt - d0 != 1) begin n_errors++; $display("FAIL ovl_complete: got beats=%0d left=%0d dones=%0d, expected 6 0 1", beats_seen - b0, exp_q.size(), done_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    int cyc, d0;
    d0 = done_cnt;
    out_ready = 1'b1;
    issue(8'h60, 3);
    wait_done(30, cyc);
    n_checks++; if (cyc < 0) begin n_errors++; $display("FAIL b2b_first: got no done, expected done"); end
    issue_now(8'h70, 2);
    tick();
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL b2b_accept: got busy=%0b, expected 1", busy); end
    wait_done(30, cyc);
    n_checks++; if (cyc < 0) begin n_errors++; $display("FAIL b2b_second: got no done, expected done"); end
    n_checks++; if (exp_q.size() != 0 || done_cnt - d0 != 2 || mem_addr !== 8'h72) begin n_errors++; $display("FAIL b2b_complete: got left=%0d dones=%0d addr=%h, expected 0 2 72", exp_q.size(), done_cnt - d0, mem_addr); end
  endtask

  task automatic test_reset_mid();
    int b0, d0, cyc;
    logic reached;
    b0 = beats_seen;
    reached = 1'b0;
    out_ready = 1'b1;
    issue(8'h40, 16);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (beats_seen - b0 >= 3) begin
        reached = 1'b1;
        break;
      end
    end
    n_checks++; if (!reached) begin n_errors++; $display("FAIL rmid_beats: got %0d beats, expected 3", beats_seen - b0); end
    @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    d0 = done_cnt;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 8'h00) begin n_errors++; $display("FAIL rmid_out: got valid=%0b last=%0b data=%h, expected 0 0 00", out_valid, out_last, out_data); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || mem_addr !== 8'h00) begin n_errors++; $display("FAIL rmid_ctl: got busy=%0b done=%0b addr=%h, expected 0 0 00", busy, done, mem_addr); end
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    n_checks++; if (done_cnt != d0 || out_valid !== 1'b0) begin n_errors++; $display("FAIL rmid_nodone: got dones=%0d valid=%0b, expected 0 0", done_cnt - d0, out_valid); end
    issue(8'h00, 2);
    wait_done(30, cyc);
    n_checks++; if (cyc < 0 || exp_q.size() != 0) begin n_errors++; $display("FAIL rmid_recover: got cyc=%0d left=%0d, expected done and 0", cyc, exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom_range(0, 255));
    test_reset();
    test_burst();
    test_wrap();
    test_backpressure();
    test_len0();
    test_overlap();
    test_back_to_back();
    test_reset_mid();
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_burst_reader.md
MEM_BURST_READER -- requirements
Module: mem_burst_reader

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits.
REQ-002 Parameter DEPTH, default 256: number of words in the attached memory.
REQ-003 Parameter AW, default 8: address width; SHALL satisfy 2**AW >= DEPTH.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  command strobe; sampled only in IDLE.
REQ-007 base_addr  input  AW  first word address of the burst; sampled with start.
REQ-008 len  input  AW+1  number of words in the burst, 0..DEPTH; sampled with start.
REQ-009 mem_addr  output  AW  read address driven to the memory.
REQ-010 mem_rdata  input  WIDTH  memory read data; combinational in mem_addr, same cycle.
REQ-011 out_valid  output  1  output beat available.
REQ-012 out_ready  input  1  downstream accepts the beat.
REQ-013 out_data  output  WIDTH  beat payload.
REQ-014 out_last  output  1  marks the final beat of the burst; qualified by out_valid.
REQ-015 busy  output  1  high from start acceptance until done.
REQ-016 done  output  1  one-cycle completion pulse.

Function
REQ-017 FSM states SHALL be IDLE, READ and DRAIN.
REQ-018 IDLE with start=1 and len>0: latch base_addr and len, then go to READ; busy=1 from the next cycle.
REQ-019 IDLE with start=1 and len=0: no beats; done=1 for exactly one cycle in the next cycle; remain in IDLE with busy=0.
REQ-020 start while busy SHALL be ignored, with no effect on state, address or count.
REQ-021 A 2-entry FIFO SHALL capture mem_rdata at mem_addr on each READ cycle in which it is not full, or is full and popped that same cycle.
REQ-022 After each capture, mem_addr SHALL increment; DEPTH-1 SHALL wrap to 0, including for non-power-of-2 DEPTH.
REQ-023 A remaining-word counter SHALL decrement per capture; when the last word is captured, go to DRAIN.
REQ-024 out_valid = FIFO not empty; out_data is the FIFO head; the pop occurs on out_valid&&out_ready.
REQ-025 out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 out_last SHALL be 1 only on the beat that holds the len-th word.
REQ-027 Latency: the first out_valid is asserted 2 cycles after the start edge (1 cycle to accept, 1 cycle to capture).
REQ-028 Throughput: 1 beat per cycle with out_ready held high; no bubbles after the first beat.
REQ-029 DRAIN: when the last beat handshakes, done=1 for one cycle in the following cycle, busy=0 in that same cycle, and the state returns to IDLE.
REQ-030 A new start is accepted in the cycle done is high.
REQ-031 In IDLE, mem_addr SHALL hold its last value and out_valid=0.

Reset
REQ-032 On rst_n=0, asynchronously: state=IDLE, FIFO empty, counters=0, mem_addr=0.
REQ-033 Output values during reset: out_valid=0, out_last=0, out_data=0, busy=0, done=0.
REQ-034 Reset asserted mid-burst SHALL discard all buffered words; no done pulse is emitted for the aborted burst.
REQ-035 Reset deassertion SHALL take effect on the next rising edge of clk; the first start is accepted on that edge or later.

Structure
REQ-036 A shared package SHALL hold the FSM state enum (IDLE, READ, DRAIN) and the FIFO depth constant (2).
REQ-037 The 2-entry FIFO SHALL be a separate sub-module, mem_burst_fifo, parameterised by WIDTH+1 (data plus last).
REQ-038 The top level SHALL hold the FSM, the address counter and the remaining-word counter.

Verification
REQ-039 Burst: base=0x10, len=4, out_ready=1 -> out_data = mem[0x10..0x13] on 4 consecutive cycles; out_last on the 4th beat; done one cycle later.
REQ-040 Wrap: base=0xFE, len=4 -> words mem[0xFE], mem[0xFF], mem[0x00], mem[0x01] in order.
REQ-041 Backpressure: len=8 with out_ready toggling 1,0,0,1... -> all 8 words delivered, none dropped or duplicated; payload stable while stalled.
REQ-042 len=0 -> no out_valid; done pulses once in the next cycle; busy stays 0.
REQ-043 Overlap: start pulsed mid-burst with a different base -> ignored; the original burst completes unchanged.
REQ-044 Reset: rst_n=0 after the 3rd beat of len=16 -> outputs clear immediately with no done; a new burst with base=0, len=2 completes normally.
